// File: rtl/cp0_ctrl_pkg.sv
// Shared definitions for the CP0 register file: register numbers, selects,
// exception codes and Status/Cause field positions.
package cp0_ctrl_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  localparam logic [2:0] SEL_0 = 3'd0;
  localparam logic [2:0] SEL_1 = 3'd1;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] CONFIG_VALUE = 32'h8000_0000;

  function automatic logic reg_hit(input logic [4:0] addr, input logic [2:0] sel,
                                   input logic [4:0] r, input logic [2:0] s);
    return (addr == r) && (sel == s);
  endfunction

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// Pipeline-to-CP0 bus: MTC0 write port, MFC0 read port and exception/ERET commit.
interface cp0_ctrl_if;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_ds;
  logic [31:0] exc_badvaddr;
  logic        eret;

  modport master (
    output we, waddr, wsel, wdata, raddr, rsel,
    output exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret,
    input  rdata
  );

  modport slave (
    input  we, waddr, wsel, wdata, raddr, rsel,
    input  exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret,
    output rdata
  );
endinterface

// File: rtl/cp0_ctrl_timer.sv
// Prescaled Count, Compare and the timer-interrupt flag (Cause.TI).
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          inc_q, inc_d;
  logic          ti_q, ti_d;
  logic          wrap;
  logic          match;

  // inc_q marks that Count just advanced, so a match is only seen on increments
  always_comb begin
    wrap      = (presc_q == PRESC_LAST);
    presc_d   = wrap ? '0 : presc_q + PW'(1);
    count_d   = wrap ? count_q + 32'd1 : count_q;
    inc_d     = wrap;
    compare_d = compare_q;
    if (count_we) begin
      count_d = wdata;
      presc_d = '0;
      inc_d   = 1'b0;
    end
    if (compare_we) begin
      compare_d = wdata;
    end
    match = inc_q && (count_q == compare_q);
    ti_d  = compare_we ? 1'b0 : (ti_q | match);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      inc_q     <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      inc_q     <= inc_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register file with exception/interrupt control; sits beside the memory
// stage and takes MTC0/MFC0, exception and ERET commits from the pipeline.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int          NUM_HW_INT    = 6,
  parameter int          COUNT_DIV     = 2,
  parameter logic [31:0] PRID_VALUE    = 32'h0000_4220,
  parameter logic [31:0] CONFIG1_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  cp0_ctrl_if.slave             bus,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic [31:0]           epc,
  output logic                  int_req,
  output logic                  timer_int
);

  logic [31:0]           status_q, status_d;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [1:0]            sw_ip_q, sw_ip_d;
  logic [NUM_HW_INT-1:0] hw_ip_q, hw_ip_d;
  logic                  bd_q, bd_d;
  logic [4:0]            exc_code_q, exc_code_d;

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic        exl;

  assign wr_count   = bus.we && reg_hit(bus.waddr, bus.wsel, CP0_COUNT,   SEL_0);
  assign wr_compare = bus.we && reg_hit(bus.waddr, bus.wsel, CP0_COMPARE, SEL_0);
  assign wr_status  = bus.we && reg_hit(bus.waddr, bus.wsel, CP0_STATUS,  SEL_0);
  assign wr_cause   = bus.we && reg_hit(bus.waddr, bus.wsel, CP0_CAUSE,   SEL_0);
  assign wr_epc     = bus.we && reg_hit(bus.waddr, bus.wsel, CP0_EPC,     SEL_0);
  assign exl        = status_q[STATUS_EXL];

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Later assignments win: exception over ERET over MTC0 for any shared field
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    sw_ip_d    = sw_ip_q;
    hw_ip_d    = hw_int;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;

    if (wr_status) begin
      status_d[STATUS_IE]          = bus.wdata[STATUS_IE];
      status_d[STATUS_IM_LO +: 8]  = bus.wdata[STATUS_IM_LO +: 8];
    end
    if (wr_cause) begin
      sw_ip_d = bus.wdata[CAUSE_IP_LO +: 2];
    end
    if (wr_epc) begin
      epc_d = bus.wdata;
    end

    if (bus.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end

    if (bus.exc_valid) begin
      status_d[STATUS_EXL] = 1'b1;
      exc_code_d           = bus.exc_code;
      if (!exl) begin
        epc_d = bus.exc_in_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
        bd_d  = bus.exc_in_ds;
      end
      if (is_addr_exc(bus.exc_code)) begin
        badvaddr_d = bus.exc_badvaddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      epc_q      <= '0;
      badvaddr_q <= '0;
      sw_ip_q    <= '0;
      hw_ip_q    <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      sw_ip_q    <= sw_ip_d;
      hw_ip_q    <= hw_ip_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
    end
  end

  // IP[7] is shared between the last hardware line and the timer
  always_comb begin
    ip      = '0;
    ip[1:0] = sw_ip_q;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      ip[2+i] = hw_ip_q[i];
    end
    ip[7] = ip[7] | ti;

    cause                      = '0;
    cause[CAUSE_BD]            = bd_q;
    cause[CAUSE_TI]            = ti;
    cause[CAUSE_IP_LO +: 8]    = ip;
    cause[CAUSE_EXC_LO +: 5]   = exc_code_q;
  end

  assign status    = status_q;
  assign epc       = epc_q;
  assign timer_int = ti;
  assign int_req   = status_q[STATUS_IE] & ~exl & (|(ip & status_q[STATUS_IM_LO +: 8]));

  always_comb begin
    bus.rdata = '0;
    if (!rst) begin
      case ({bus.raddr, bus.rsel})
        {CP0_BADVADDR, SEL_0}: bus.rdata = badvaddr_q;
        {CP0_COUNT,    SEL_0}: bus.rdata = count;
        {CP0_COMPARE,  SEL_0}: bus.rdata = compare;
        {CP0_STATUS,   SEL_0}: bus.rdata = status_q;
        {CP0_CAUSE,    SEL_0}: bus.rdata = cause;
        {CP0_EPC,      SEL_0}: bus.rdata = epc_q;
        {CP0_PRID,     SEL_0}: bus.rdata = PRID_VALUE;
        {CP0_CONFIG,   SEL_0}: bus.rdata = CONFIG_VALUE;
        {CP0_CONFIG,   SEL_1}: bus.rdata = CONFIG1_VALUE;
        default:               bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Parametrised second-generation coprocessor-0 register file and exception/interrupt controller for the MIPS-style pipeline; sits beside the memory stage.
- Adds over the current CP0:
  - hardware interrupt sampling and an interrupt-request output;
  - a prescaled Count;
  - EXL-nesting rules for EPC;
  - generic exception-code capture;
  - sel-field decode with read-only PRId/Config/Config1.

Parameters:
- NUM_HW_INT, 6: hardware interrupt lines, 1..6, mapped to Cause.IP[2+i].
- COUNT_DIV, 2: clocks per Count increment, >=1.
- PRID_VALUE, 32'h00004220: PRId read value.
- CONFIG1_VALUE, 32'h0: Config1 read value.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- we  in  1  MTC0 write enable
- waddr  in  5  MTC0 register number
- wsel  in  3  MTC0 select
- wdata  in  32  MTC0 data
- raddr  in  5  MFC0 register number
- rsel  in  3  MFC0 select
- rdata  out  32  MFC0 read data, combinational
- hw_int  in  NUM_HW_INT  level hardware interrupts
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  ExcCode to record
- exc_pc  in  32  PC of the faulting instruction
- exc_in_ds  in  1  faulting instruction is in a delay slot
- exc_badvaddr  in  32  faulting virtual address
- eret  in  1  ERET commit
- status  out  32  Status register
- cause  out  32  Cause register
- epc  out  32  EPC register
- int_req  out  1  pending enabled interrupt, combinational from registers
- timer_int  out  1  Cause.TI

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All register updates happen on the posedge.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1).
  - Cause, EPC, BadVAddr, Count, Compare, prescaler = 0.
  - rdata = 0 while rst is high; int_req = 0 and timer_int = 0.
- Registers, as (reg, sel):
  - (8,0) BadVAddr, read-only.
  - (9,0) Count, RW.
  - (11,0) Compare, RW.
  - (12,0) Status; writable bits are IE[0] and IM[15:8].
  - (13,0) Cause; writable bits are IP[9:8].
  - (14,0) EPC, RW.
  - (15,0) PRId, read-only.
  - (16,0) Config = 32'h8000_0000, read-only.
  - (16,1) Config1, read-only.
  - Any other reg/sel reads 0. Writes to them are ignored.
- Prescaler:
  - Counts 0..COUNT_DIV-1. Count increments by 1 when the prescaler wraps; Count wraps from 32'hFFFFFFFF to 0.
  - Writing Count loads wdata and clears the prescaler; the write wins over the increment.
- Timer:
  - Cause.TI (bit 30) sets the cycle after Count equals Compare at an increment edge, including Compare=0.
  - Cleared only by a Compare write. A Compare write in the same cycle as a match clears TI.
- Hardware interrupts:
  - Cause.IP[2+i] is sampled from hw_int[i] every cycle, giving 1-cycle latency.
  - Cause.IP[7] = hw_int[5] (if present) OR TI.
  - Unused IP bits are 0.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- Exception commit (exc_valid):
  - If Status.EXL = 0:
    - EPC = exc_in_ds ? exc_pc-4 : exc_pc;
    - Cause.BD = exc_in_ds.
  - If Status.EXL = 1, EPC and BD are unchanged (nested exception).
  - Always: EXL = 1 and Cause.ExcCode[6:2] = exc_code.
  - BadVAddr = exc_badvaddr when exc_code is 4 (AdEL) or 5 (AdES); otherwise unchanged.
  - exc_code 0 (Int) is recorded like any other code.
- eret: Status.EXL = 0.
- Same-cycle priority: exc_valid > eret > MTC0 write to the same field.
  - Example: an exception overrides an MTC0 write to EPC.
  - An MTC0 write to Status.IE still applies alongside an exception, since the fields differ.
  - Count/Compare writes are unaffected by exceptions.
- Reads: rdata shows the pre-update register value. There is no write-to-read forwarding; the pipeline handles hazards.
- Reset mid-operation overrides everything: all registers return to their reset values the next cycle.

Decomposition:
- Shared package (defines header) holds:
  - CP0 register numbers and sel values;
  - ExcCode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12);
  - Status/Cause bit-position constants.
- One natural sub-module, cp0_timer: prescaler, Count, Compare, match detection, TI flag.

Test Plan:
1. Reset, then read (12,0) -> 32'h0040_0000; read (15,0) -> PRID_VALUE; read (16,1) -> CONFIG1_VALUE; read (10,0) -> 0.
2. COUNT_DIV=2. Write Count=5, then wait 6 clocks -> Count=8. Write Compare=10 -> TI=1 at the increment to 10, plus 1 cycle. Write Compare=0 -> TI=0 next cycle.
3. Status = 32'h0000_0401 (IE=1, IM2=1). Raise hw_int[0] -> Cause.IP2 = 1 after 1 cycle and int_req = 1. Set EXL via an exception -> int_req = 0.
4. exc_valid with exc_code=4, exc_pc=32'hBFC0_0100, exc_in_ds=1, badvaddr=32'h0000_0003 -> EPC = 32'hBFC0_00FC, BD=1, ExcCode=4, BadVAddr=3, EXL=1.
5. Second exception with EXL=1, exc_code=12, exc_pc=32'h8000_0000 -> EPC unchanged, ExcCode=12. eret -> EXL=0.
6. Same cycle: exc_valid (pc=32'h100, no delay slot) plus MTC0 EPC=32'h200 -> EPC = 32'h100. Count write plus a prescaler wrap -> Count = wdata.
